// File: rtl/command_parser_multi_if.sv
// Byte-stream and command handshake between UART RX, the command parser and the main FSM.
// The master side drives bytes and acks; the slave side is the parser.
interface command_parser_multi_if #(
  parameter int unsigned SEL_W   = 1,
  parameter int unsigned N_WIDTH = 10
);
  logic [7:0]         rx_byte;
  logic               rx_valid;
  logic               cmd_ack;
  logic               cmd_ready;
  logic [SEL_W-1:0]   cmd_sel;
  logic [N_WIDTH-1:0] n_value;
  logic               err_valid;
  logic [2:0]         err_code;

  modport master (
    output rx_byte, rx_valid, cmd_ack,
    input  cmd_ready, cmd_sel, n_value, err_valid, err_code
  );

  modport slave (
    input  rx_byte, rx_valid, cmd_ack,
    output cmd_ready, cmd_sel, n_value, err_valid, err_code
  );
endinterface

// File: rtl/command_parser_multi.sv
// Parses "<letter>,<digits><LF|CR>" commands from a UART byte stream, holds the result until
// acknowledged and reports malformed input as a coded one-cycle error pulse.
module command_parser_multi #(
  parameter int unsigned           NUM_CMDS    = 2,
  parameter logic [NUM_CMDS*8-1:0] CMD_CHARS   = {"M", "P"},
  parameter int unsigned           MAX_DIGITS  = 3,
  parameter int unsigned           N_WIDTH     = 10,
  parameter int unsigned           N_MAX       = 500,
  parameter int unsigned           TIMEOUT_CYC = 0,
  localparam int unsigned          SEL_W       = (NUM_CMDS > 1) ? $clog2(NUM_CMDS) : 1
) (
  input logic                   clk,
  input logic                   reset,
  command_parser_multi_if.slave bus
);
  localparam int unsigned AccW = $clog2(10 ** MAX_DIGITS);
  localparam int unsigned CntW = $clog2(MAX_DIGITS + 1);
  localparam int unsigned TimW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  localparam logic [2:0] ErrBadSep   = 3'd1;
  localparam logic [2:0] ErrBadChar  = 3'd2;
  localparam logic [2:0] ErrOverlong = 3'd3;
  localparam logic [2:0] ErrEmpty    = 3'd4;
  localparam logic [2:0] ErrRange    = 3'd5;
  localparam logic [2:0] ErrTimeout  = 3'd6;
  localparam logic [2:0] ErrOverrun  = 3'd7;

  typedef enum logic [1:0] {StIdle, StComma, StDigits, StDone} state_e;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [AccW-1:0]    acc_q, acc_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [TimW-1:0]    timer_q, timer_d;
  logic [SEL_W-1:0]   cmd_sel_q, cmd_sel_d;
  logic [N_WIDTH-1:0] n_value_q, n_value_d;
  logic               err_valid_q, err_valid_d;
  logic [2:0]         err_code_q, err_code_d;

  logic             match_hit;
  logic [SEL_W-1:0] match_idx;
  logic             is_digit, is_term;
  logic [31:0]      acc_next;

  // Scan from the top so the lowest matching index wins on duplicate letters.
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    for (int i = NUM_CMDS - 1; i >= 0; i--) begin
      if (bus.rx_byte == CMD_CHARS[8*i +: 8]) begin
        match_hit = 1'b1;
        match_idx = SEL_W'(i);
      end
    end
  end

  assign is_digit = (bus.rx_byte >= 8'h30) && (bus.rx_byte <= 8'h39);
  assign is_term  = (bus.rx_byte == 8'h0a) || (bus.rx_byte == 8'h0d);
  assign acc_next = 32'(acc_q) * 32'd10 + 32'(bus.rx_byte[3:0]);

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    timer_d     = '0;
    cmd_sel_d   = cmd_sel_q;
    n_value_d   = n_value_q;
    err_valid_d = 1'b0;
    err_code_d  = err_code_q;

    unique case (state_q)
      StIdle: begin
        if (bus.rx_valid && match_hit) begin
          sel_d   = match_idx;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StComma;
        end
      end

      StComma, StDigits: begin
        if (!bus.rx_valid) begin
          if (TIMEOUT_CYC != 0) begin
            if (timer_q == TimW'(TIMEOUT_CYC - 1)) begin
              err_valid_d = 1'b1;
              err_code_d  = ErrTimeout;
              state_d     = StIdle;
            end else begin
              timer_d = timer_q + TimW'(1);
            end
          end
        end else if (state_q == StComma) begin
          if (bus.rx_byte == 8'h2c) begin
            state_d = StDigits;
          end else begin
            err_valid_d = 1'b1;
            err_code_d  = ErrBadSep;
            state_d     = StIdle;
          end
        end else if (is_digit) begin
          if (cnt_q == CntW'(MAX_DIGITS)) begin
            err_valid_d = 1'b1;
            err_code_d  = ErrOverlong;
            state_d     = StIdle;
          end else begin
            acc_d = AccW'(acc_next);
            cnt_d = cnt_q + CntW'(1);
          end
        end else if (is_term) begin
          if (cnt_q == '0) begin
            err_valid_d = 1'b1;
            err_code_d  = ErrEmpty;
            state_d     = StIdle;
          end else if (32'(acc_q) > N_MAX) begin
            err_valid_d = 1'b1;
            err_code_d  = ErrRange;
            state_d     = StIdle;
          end else begin
            n_value_d = N_WIDTH'(acc_q);
            cmd_sel_d = sel_q;
            state_d   = StDone;
          end
        end else begin
          err_valid_d = 1'b1;
          err_code_d  = ErrBadChar;
          state_d     = StIdle;
        end
      end

      StDone: begin
        // A byte here is dropped even when the ack lands in the same cycle.
        if (bus.rx_valid) begin
          err_valid_d = 1'b1;
          err_code_d  = ErrOverrun;
        end
        if (bus.cmd_ack) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      sel_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      timer_q     <= '0;
      cmd_sel_q   <= '0;
      n_value_q   <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      timer_q     <= timer_d;
      cmd_sel_q   <= cmd_sel_d;
      n_value_q   <= n_value_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
    end
  end

  assign bus.cmd_ready = (state_q == StDone);
  assign bus.cmd_sel   = cmd_sel_q;
  assign bus.n_value   = n_value_q;
  assign bus.err_valid = err_valid_q;
  assign bus.err_code  = err_code_q;

endmodule

// File: tb/tb_command_parser_multi.sv
// Bench for command_parser_multi: directed string table, hand-written corner sequences and
// random byte streams, all checked cycle by cycle against a queue-based command model.
module tb_command_parser_multi;
  localparam int TO   = 20;
  localparam int MAXD = 3;
  localparam int NMAX = 500;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  command_parser_multi_if #(.SEL_W(1), .N_WIDTH(10)) bus ();

  command_parser_multi #(
    .NUM_CMDS   (2),
    .CMD_CHARS  ({"M", "P"}),
    .MAX_DIGITS (MAXD),
    .N_WIDTH    (10),
    .N_MAX      (NMAX),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: text of the command in progress plus the held result.
  logic [7:0] m_buf[$];
  int         m_pend_sel;
  bit         m_held;
  int         m_sel, m_val, m_errc, m_gap;
  bit         m_errv;

  typedef struct {
    string txt;
    int    rdy;
    int    sel;
    int    val;
    int    errc;
  } vec_t;
  vec_t vecs[9];

  logic [7:0] alpha[16];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int letter_idx(input logic [7:0] b);
    if (b == 8'h50) return 0;
    if (b == 8'h4d) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    m_buf.delete();
    m_pend_sel = 0;
    m_held = 0;
    m_sel = 0;
    m_val = 0;
    m_errc = 0;
    m_errv = 0;
    m_gap = 0;
  endtask

  task automatic raise(input int code);
    m_errv = 1;
    m_errc = code;
    m_buf.delete();
  endtask

  task automatic model_step(input bit v, input logic [7:0] b, input bit ack);
    int ndig, val;
    m_errv = 0;
    if (m_held) begin
      if (v) raise(7);
      if (ack) m_held = 0;
    end else if (m_buf.size() == 0) begin
      if (v && letter_idx(b) >= 0) begin
        m_buf.push_back(b);
        m_pend_sel = letter_idx(b);
        m_gap = 0;
      end
    end else if (!v) begin
      m_gap++;
      if (m_gap == TO) raise(6);
    end else begin
      m_gap = 0;
      if (m_buf.size() == 1) begin
        if (b == 8'h2c) m_buf.push_back(b);
        else raise(1);
      end else begin
        ndig = m_buf.size() - 2;
        if (b >= 8'h30 && b <= 8'h39) begin
          if (ndig == MAXD) raise(3);
          else m_buf.push_back(b);
        end else if (b == 8'h0a || b == 8'h0d) begin
          if (ndig == 0) begin
            raise(4);
          end else begin
            val = 0;
            for (int i = 2; i < m_buf.size(); i++) val = val * 10 + int'(m_buf[i] - 8'h30);
            if (val > NMAX) begin
              raise(5);
            end else begin
              m_held = 1;
              m_sel = m_pend_sel;
              m_val = val;
              m_buf.delete();
            end
          end
        end else begin
          raise(2);
        end
      end
    end
  endtask

  task automatic check_model();
    check("cmd_ready", int'(bus.cmd_ready), int'(m_held));
    check("cmd_sel", int'(bus.cmd_sel), m_sel);
    check("n_value", int'(bus.n_value), m_val);
    check("err_valid", int'(bus.err_valid), int'(m_errv));
    check("err_code", int'(bus.err_code), m_errc);
  endtask

  // One clock: drive on the falling edge, update the model at the rising edge, compare 1ns later.
  task automatic step(input bit v, input logic [7:0] b, input bit ack);
    @(negedge clk);
    bus.rx_valid = v;
    bus.rx_byte  = b;
    bus.cmd_ack  = ack;
    @(posedge clk);
    model_step(v, b, ack);
    #1;
    check_model();
    bus.rx_valid = 1'b0;
    bus.cmd_ack  = 1'b0;
  endtask

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) step(1'b1, s[i], 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"M,42\n",    1, 1, 42,  0};
    vecs[1] = '{"P,7\r",     1, 0, 7,   0};
    vecs[2] = '{"P,500\n",   1, 0, 500, 0};
    vecs[3] = '{"P,501\n",   0, 0, 500, 5};
    vecs[4] = '{"P,0007\n",  0, 0, 500, 3};
    vecs[5] = '{"xyzP;M,1\n", 1, 1, 1,  1};
    vecs[6] = '{"P,\n",      0, 1, 1,   4};
    vecs[7] = '{"P,1a\n",    0, 1, 1,   2};
    vecs[8] = '{"M,0\r",     1, 1, 0,   2};

    alpha = '{8'h4d, 8'h50, 8'h2c, 8'h2c, 8'h30, 8'h31, 8'h32, 8'h35,
              8'h37, 8'h39, 8'h34, 8'h0a, 8'h0d, 8'h0a, 8'h78, 8'h3b};

    bus.rx_valid = 1'b0;
    bus.rx_byte  = 8'h00;
    bus.cmd_ack  = 1'b0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check_model();
    @(negedge clk);
    reset = 1'b0;

    // Directed table.
    for (int t = 0; t < 9; t++) begin
      send(vecs[t].txt);
      idle(5);
      check("tbl_ready", int'(bus.cmd_ready), vecs[t].rdy);
      check("tbl_sel", int'(bus.cmd_sel), vecs[t].sel);
      check("tbl_value", int'(bus.n_value), vecs[t].val);
      check("tbl_errcode", int'(bus.err_code), vecs[t].errc);
      if (vecs[t].rdy != 0) begin
        step(1'b0, 8'h00, 1'b1);
        check("tbl_ack_release", int'(bus.cmd_ready), 0);
      end
    end

    // Overrun: byte while held, then byte in the same cycle as the ack.
    send("M,9\n");
    step(1'b1, 8'h50, 1'b0);
    check("ovr_errcode", int'(bus.err_code), 7);
    check("ovr_still_held", int'(bus.cmd_ready), 1);
    check("ovr_value_kept", int'(bus.n_value), 9);
    step(1'b1, 8'h4d, 1'b1);
    check("ovr_ack_pulse", int'(bus.err_valid), 1);
    check("ovr_ack_release", int'(bus.cmd_ready), 0);
    step(1'b1, 8'h50, 1'b0);
    check("ack_then_letter_no_err", int'(bus.err_valid), 0);
    send(",3\n");
    check("ack_then_letter_cmd", int'(bus.n_value), 3);
    step(1'b0, 8'h00, 1'b1);

    // Timeout fires exactly TO cycles after the last byte.
    send("P,1");
    for (int k = 1; k <= TO; k++) begin
      step(1'b0, 8'h00, 1'b0);
      if (k == TO - 1) check("to_not_early", int'(bus.err_valid), 0);
      if (k == TO) begin
        check("to_fires", int'(bus.err_valid), 1);
        check("to_code", int'(bus.err_code), 6);
      end
    end
    send("P,1");
    idle(TO - 1);
    send("\n");
    check("to_gap_ok_ready", int'(bus.cmd_ready), 1);
    check("to_gap_ok_value", int'(bus.n_value), 1);
    step(1'b0, 8'h00, 1'b1);

    // Asynchronous reset in the middle of a command.
    send("M,");
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_model();
    @(negedge clk);
    reset = 1'b0;
    send("3\n");
    idle(2);
    check("rst_no_cmd", int'(bus.cmd_ready), 0);
    check("rst_no_err", int'(bus.err_code), 0);

    // Random byte streams with random acks and occasional long gaps.
    for (int n = 0; n < 2500; n++) begin
      int r;
      bit ack;
      r = int'($urandom_range(0, 99));
      ack = (m_held && ($urandom_range(0, 3) == 0)) || ($urandom_range(0, 19) == 0);
      if (r < 65) begin
        step(1'b1, alpha[$urandom_range(0, 15)], ack);
      end else if (r < 97) begin
        step(1'b0, 8'h00, ack);
      end else begin
        idle(int'($urandom_range(15, 24)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/command_parser_multi.md
# command_parser_multi

Parametrised successor to the single-letter UART command parser. Consumes the byte stream from UART RX and decodes commands of the form `<letter>,<decimal digits><LF|CR>`. Supports a configurable command-letter set, up to MAX_DIGITS digits, range checking and an inter-byte timeout. Completed commands are held until the main FSM acknowledges them; malformed input raises a coded error pulse.

## Interface
- NUM_CMDS, 2: number of command letters, ≥1.
- CMD_CHARS, {"M","P"}: packed NUM_CMDS×8 bits; letter i occupies bits [8i+7:8i], so index 0 = "P" and index 1 = "M".
- MAX_DIGITS, 3: maximum digit count, ≥1.
- N_WIDTH, 10: n_value width; 2**N_WIDTH > N_MAX.
- N_MAX, 500: largest accepted value.
- TIMEOUT_CYC, 0: idle cycles allowed between bytes inside a command; 0 disables the timeout.
- SEL_W, derived: max(1, $clog2(NUM_CMDS)).
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- rx_byte  in  8  received byte, valid when rx_valid is high.
- rx_valid  in  1  one-cycle strobe per byte.
- cmd_ack  in  1  main FSM has consumed the command.
- cmd_ready  out  1  command held in cmd_sel / n_value.
- cmd_sel  out  SEL_W  index of the matched letter.
- n_value  out  N_WIDTH  parsed value.
- err_valid  out  1  one-cycle error pulse.
- err_code  out  3  last error: 1 BAD_SEP, 2 BAD_CHAR, 3 OVERLONG, 4 EMPTY, 5 RANGE, 6 TIMEOUT, 7 OVERRUN.

## Operation
- States: S_IDLE, S_COMMA, S_DIGITS, S_DONE. Reset enters S_IDLE.
- Reset values: cmd_ready=0, cmd_sel=0, n_value=0, err_valid=0, err_code=0. Internal accumulator, digit count and timer are also 0.
- S_IDLE, on byte:
  - Matches CMD_CHARS[i] → latch index i, clear accumulator and digit count, go to S_COMMA. If letters repeat, the lowest index wins.
  - Any other byte → ignored silently, no error.
- S_COMMA, on byte:
  - "," → go to S_DIGITS.
  - Anything else → BAD_SEP, go to S_IDLE. The offending byte is consumed and not reinterpreted, even if it is a command letter.
- S_DIGITS, on byte:
  - "0".."9" → acc = acc*10 + digit, count++. Leading zeros count as digits. A digit arriving with count == MAX_DIGITS → OVERLONG, go to S_IDLE.
  - LF (0x0A) or CR (0x0D):
    - count == 0 → EMPTY, go to S_IDLE.
    - acc > N_MAX → RANGE, go to S_IDLE.
    - Otherwise → n_value ← acc[N_WIDTH-1:0], cmd_sel ← latched index, go to S_DONE.
  - Any other byte → BAD_CHAR, go to S_IDLE.
- Accumulator width is wide enough for 10**MAX_DIGITS − 1, so no overflow is possible before the range check.
- S_DONE: cmd_ready=1; cmd_sel and n_value are stable. cmd_ack → S_IDLE. A byte arriving in S_DONE is dropped and raises OVERRUN, whether or not cmd_ack is high in the same cycle. The command is still held, or released if acked.
- Timeout (TIMEOUT_CYC>0): timer clears on entering S_COMMA and on every rx_valid in S_COMMA/S_DIGITS, and increments otherwise. Reaching TIMEOUT_CYC → TIMEOUT, go to S_IDLE. The timer is inactive in S_IDLE and S_DONE.
- Errors: err_valid pulses for exactly one cycle and err_code is updated in the same cycle. err_code holds until the next error; it is cleared only by reset. Only one error per cycle is possible.
- cmd_ack outside S_DONE is ignored.
- Reset mid-command: asynchronous return to S_IDLE with all outputs at reset values, including clearing a held command.

## Timing
- All outputs are registered. cmd_ready is decoded from the state register.
- Terminator sampled at edge t → cmd_ready, cmd_sel and n_value valid after edge t. Latency is 1 cycle.
- Offending byte at edge t → err_valid high for the cycle after edge t. The next byte at edge t+1 is already parsed from S_IDLE.
- cmd_ack sampled at edge t → cmd_ready low after edge t. A letter at edge t+1 is accepted.
- Back-to-back rx_valid on every cycle must be handled without loss, except the documented drops in S_DONE.
- Timeout fires on the edge where the count reaches TIMEOUT_CYC: exactly TIMEOUT_CYC cycles after the last accepted byte.

## Test plan
- Valid command: "M,42\n" → cmd_ready=1, cmd_sel=1, n_value=42. Hold 5 cycles, then cmd_ack → cmd_ready=0 next cycle. Then "P,7\r" → cmd_sel=0, n_value=7.
- Limits: "P,500\n" → n_value=500. "P,501\n" → err_code=5, no cmd_ready. "P,0007\n" → err_code=3 on the fourth digit; the following "\n" is ignored in S_IDLE.
- Malformed input: "xyzP;M,1\n" → x, y, z ignored; ";" → err_code=1; "M,1\n" is then accepted with cmd_sel=1, n_value=1. "P,\n" → err_code=4. "P,1a\n" → err_code=2.
- Overrun: after "M,9\n", send "P" with no ack → err_code=7; the held command is unchanged. Send a byte in the same cycle as cmd_ack → byte dropped, err_code=7, cmd_ready=0.
- Timeout (TIMEOUT_CYC=20): "P,1", then 20 idle cycles → err_code=6 exactly 20 cycles after "1". With a gap of 19 cycles before "\n" → accepted, n_value=1.
- Reset: assert reset between "M," and "3" → all outputs 0. The subsequent "3\n" produces nothing.
